// File: rtl/mfm_dpll_track.sv
// MFM data-separator DPLL: recovers the bit-window clock from raw MFM pulses
// with bounded proportional phase correction, lock detection and
// loss-of-signal recovery.
// Optional: define MFM_DPLL_STATS_EN to add pulse_count / unlock_count outputs.
module mfm_dpll_track #(
  parameter int unsigned HALF_PERIOD  = 5,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned MAX_ADJ      = 1,
  parameter int unsigned LOCK_COUNT   = 8,
  parameter int unsigned LOSS_TIMEOUT = 16
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             raw_mfm,
  output logic             clk_5,
  output logic             mfm_bit,
  output logic             bit_valid,
  output logic             locked,
  output logic [CNT_W-1:0] phase_err
`ifdef MFM_DPLL_STATS_EN
  ,
  output logic [15:0]      pulse_count,
  output logic [7:0]       unlock_count
`endif
);

  localparam int unsigned C       = HALF_PERIOD / 2;
  localparam int unsigned ERR_W   = CNT_W + 1;
  localparam int unsigned GOOD_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned EMPTY_W = $clog2(LOSS_TIMEOUT + 1);
  localparam logic signed [ERR_W-1:0] MAX_S = ERR_W'(MAX_ADJ);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t                    state, state_nxt;
  logic                      sync1, sync2, prev;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic signed [CNT_W-1:0]   adj, adj_nxt, pend, pend_nxt;
  logic                      seen, seen_nxt;
  logic [GOOD_W-1:0]         good, good_nxt;
  logic [EMPTY_W-1:0]        empty, empty_nxt;
  logic                      clk_5_nxt, mfm_bit_nxt, bit_valid_nxt, locked_nxt;
  logic [CNT_W-1:0]          phase_err_nxt;

  logic                      pulse_edge_c, first_c, close_c, timeout_c, accept_c, in_tol_c;
  logic [CNT_W-1:0]          term_c;
  logic signed [ERR_W-1:0]   err_c, clamp_c;

  // Rising-edge detect on the synchronised pulse line
  assign pulse_edge_c = sync2 & ~prev;
  assign term_c       = CNT_W'(HALF_PERIOD - 1) + $unsigned(adj);
  assign close_c      = (state == TRACK) && (cnt == term_c);
  assign timeout_c    = (state == TRACK) && (empty == EMPTY_W'(LOSS_TIMEOUT));
  assign first_c      = (state == TRACK) && pulse_edge_c && !seen;
  assign accept_c     = first_c && enable && !timeout_c;
  assign err_c        = $signed({1'b0, cnt}) - $signed(ERR_W'(C));
  assign in_tol_c     = (err_c <= MAX_S) && (err_c >= -MAX_S);

  // Clamp the phase error to the per-window correction limit
  always_comb begin
    clamp_c = err_c;
    if (err_c > MAX_S)       clamp_c = MAX_S;
    else if (err_c < -MAX_S) clamp_c = -MAX_S;
  end

  // Synchroniser and state/output registers
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev      <= 1'b0;
      state     <= HUNT;
      cnt       <= '0;
      adj       <= '0;
      pend      <= '0;
      seen      <= 1'b0;
      good      <= '0;
      empty     <= '0;
      clk_5     <= 1'b0;
      mfm_bit   <= 1'b0;
      bit_valid <= 1'b0;
      locked    <= 1'b0;
      phase_err <= '0;
    end else begin
      sync1     <= raw_mfm;
      sync2     <= sync1;
      prev      <= sync2;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      adj       <= adj_nxt;
      pend      <= pend_nxt;
      seen      <= seen_nxt;
      good      <= good_nxt;
      empty     <= empty_nxt;
      clk_5     <= clk_5_nxt;
      mfm_bit   <= mfm_bit_nxt;
      bit_valid <= bit_valid_nxt;
      locked    <= locked_nxt;
      phase_err <= phase_err_nxt;
    end
  end

  // Next-state: hunt for first edge, then track windows and correct phase
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    adj_nxt       = adj;
    pend_nxt      = pend;
    seen_nxt      = seen;
    good_nxt      = good;
    empty_nxt     = empty;
    clk_5_nxt     = clk_5;
    mfm_bit_nxt   = mfm_bit;
    bit_valid_nxt = 1'b0;
    locked_nxt    = locked;
    phase_err_nxt = phase_err;
    case (state)
      HUNT: begin
        clk_5_nxt = 1'b0;
        cnt_nxt   = '0;
        if (enable && pulse_edge_c) begin
          state_nxt = TRACK;
          cnt_nxt   = CNT_W'(C + 1);
          seen_nxt  = 1'b1;
        end
      end
      TRACK: begin
        if (!enable || timeout_c) begin
          state_nxt  = HUNT;
          locked_nxt = 1'b0;
          clk_5_nxt  = 1'b0;
          cnt_nxt    = '0;
          adj_nxt    = '0;
          pend_nxt   = '0;
          seen_nxt   = 1'b0;
          good_nxt   = '0;
          empty_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (first_c) begin
            phase_err_nxt = CNT_W'(err_c);
            pend_nxt      = CNT_W'(clamp_c);
            seen_nxt      = 1'b1;
            if (in_tol_c) begin
              if (good >= GOOD_W'(LOCK_COUNT - 1)) begin
                good_nxt   = GOOD_W'(LOCK_COUNT);
                locked_nxt = 1'b1;
              end else begin
                good_nxt = good + GOOD_W'(1);
              end
            end else begin
              good_nxt = '0;
            end
          end
          if (close_c) begin
            clk_5_nxt     = ~clk_5;
            cnt_nxt       = '0;
            mfm_bit_nxt   = seen | pulse_edge_c;
            bit_valid_nxt = 1'b1;
            seen_nxt      = 1'b0;
            adj_nxt       = first_c ? CNT_W'(clamp_c) : pend;
            pend_nxt      = '0;
            if (seen || pulse_edge_c)                    empty_nxt = '0;
            else if (empty < EMPTY_W'(LOSS_TIMEOUT))     empty_nxt = empty + EMPTY_W'(1);
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

`ifdef MFM_DPLL_STATS_EN
  // Saturating accepted-pulse and lock-loss statistics
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      pulse_count  <= '0;
      unlock_count <= '0;
    end else begin
      if (accept_c && (pulse_count != 16'hFFFF))
        pulse_count <= pulse_count + 16'd1;
      if (locked && !locked_nxt && (unlock_count != 8'hFF))
        unlock_count <= unlock_count + 8'd1;
    end
  end
`endif

endmodule
